// File: rtl/divisor_sequencial.sv
// Key-stepped unsigned restoring divider: operands are keyed in on din/dv,
// one quotient bit is produced per clock, then quotient and remainder are shown.
module divisor_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dv,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             divZero,
    output logic [2:0]       prStateLed,
    output logic [2:0]       nxStateLed
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] CALC   = 3'd3;
    localparam logic [2:0] SHOW_Q = 3'd4;
    localparam logic [2:0] SHOW_R = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             dv_q;
    logic             dv_rise;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             div_zero;
    logic [WIDTH:0]   t;
    logic             ge;

    // dv_q resets high so a key held through reset is not seen as a press
    assign dv_rise = dv & ~dv_q;
    assign t       = {rem, quo[WIDTH-1]};
    assign ge      = (t >= {1'b0, b_reg});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dv_q  <= 1'b1;
        end else begin
            state <= state_nx;
            dv_q  <= dv;
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = dv_rise ? LOAD_A : IDLE;
            LOAD_A:  state_nx = dv_rise ? LOAD_B : LOAD_A;
            LOAD_B: begin
                state_nx = LOAD_B;
                if (dv_rise) state_nx = (din != '0) ? CALC : SHOW_Q;
            end
            CALC:    state_nx = (cnt == LAST) ? SHOW_Q : CALC;
            SHOW_Q:  state_nx = dv_rise ? SHOW_R : SHOW_Q;
            SHOW_R:  state_nx = dv_rise ? IDLE : SHOW_R;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dout       = '0;
        busy       = 1'b0;
        divZero    = 1'b0;
        prStateLed = state;
        nxStateLed = reset ? 3'd0 : state_nx;
        case (state)
            LOAD_A, LOAD_B: begin
                dout    = din;
                divZero = div_zero;
            end
            CALC: begin
                busy    = 1'b1;
                divZero = div_zero;
            end
            SHOW_Q: begin
                dout    = quo;
                divZero = div_zero;
            end
            SHOW_R: begin
                dout    = rem;
                divZero = div_zero;
            end
            IDLE:    divZero = div_zero;
            default: prStateLed = state;
        endcase
    end

    // Datapath: each register is written only in the state that owns it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (dv_rise) a_reg <= din;
                LOAD_B: begin
                    if (dv_rise) begin
                        b_reg <= din;
                        if (din != '0) begin
                            rem <= '0;
                            quo <= a_reg;
                            cnt <= '0;
                        end else begin
                            quo      <= '1;
                            rem      <= a_reg;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    // t - B always fits in WIDTH bits because rem < B
                    quo <= {quo[WIDTH-2:0], ge};
                    rem <= ge ? (t[WIDTH-1:0] - b_reg) : t[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                SHOW_R: if (dv_rise) div_zero <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed bench for divisor_sequencial: WIDTH=8 vector table, one WIDTH=16
// division, and hand-written key-hold, press-during-CALC and mid-CALC reset sequences.
module tb_divisor_sequencial;

    logic        clock = 1'b0;
    logic        reset;
    logic        dv8, dv16;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        busy8, busy16, dz8, dz16;
    logic [2:0]  pr8, pr16, nx8, nx16;

    int checks = 0;
    int fails  = 0;
    logic sel16 = 1'b0;

    logic [15:0] m_dout;
    logic        m_busy, m_dz;
    logic [2:0]  m_pr;

    always #5 clock = ~clock;

    divisor_sequencial #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .dv(dv8), .din(din8), .dout(dout8),
        .busy(busy8), .divZero(dz8), .prStateLed(pr8), .nxStateLed(nx8)
    );

    divisor_sequencial #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .dv(dv16), .din(din16), .dout(dout16),
        .busy(busy16), .divZero(dz16), .prStateLed(pr16), .nxStateLed(nx16)
    );

    always_comb begin
        m_dout = sel16 ? dout16 : {8'd0, dout8};
        m_busy = sel16 ? busy16 : busy8;
        m_dz   = sel16 ? dz16 : dz8;
        m_pr   = sel16 ? pr16 : pr8;
    end

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        if (sel16) begin
            din16 = v;
            dv16  = 1'b1;
        end else begin
            din8 = v[7:0];
            dv8  = 1'b1;
        end
        @(negedge clock);
        dv8  = 1'b0;
        dv16 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_div(input int a, input int b, input int q, input int r,
                           input int dz, input int w);
        int count;
        press(16'd0);
        check("enter LOAD_A", m_pr, 1);
        press(16'(a));
        check("enter LOAD_B", m_pr, 2);
        if (sel16) din16 = 16'hA5A5; else din8 = 8'h5A;
        #1 check("live din in LOAD_B", m_dout, sel16 ? 16'hA5A5 : 16'h005A);
        press(16'(b));
        count = 0;
        while (m_busy && count < 64) begin
            count++;
            @(negedge clock);
        end
        check("busy cycles", count, (b == 0) ? 0 : w);
        check("state SHOW_Q", m_pr, 4);
        check("quotient", m_dout, q);
        check("divZero in SHOW_Q", m_dz, dz);
        press(16'd0);
        check("state SHOW_R", m_pr, 5);
        check("remainder", m_dout, r);
        check("divZero in SHOW_R", m_dz, dz);
        press(16'd0);
        check("back to IDLE", m_pr, 0);
        check("divZero cleared", m_dz, 0);
        check("dout in IDLE", m_dout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{a: 100, b: 7,  q: 14,  r: 2,  dz: 0};
        vecs[1] = '{a: 37,  b: 0,  q: 255, r: 37, dz: 1};
        vecs[2] = '{a: 5,   b: 9,  q: 0,   r: 5,  dz: 0};
        vecs[3] = '{a: 255, b: 1,  q: 255, r: 0,  dz: 0};
        vecs[4] = '{a: 0,   b: 3,  q: 0,   r: 0,  dz: 0};
        vecs[5] = '{a: 200, b: 13, q: 15,  r: 5,  dz: 0};

        reset = 1'b1;
        dv8   = 1'b0;
        dv16  = 1'b0;
        din8  = 8'd0;
        din16 = 16'd0;
        #1;
        check("reset dout", dout8, 0);
        check("reset busy", busy8, 0);
        check("reset divZero", dz8, 0);
        check("reset prStateLed", pr8, 0);
        check("reset nxStateLed", nx8, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 8);

        sel16 = 1'b1;
        run_div(50000, 300, 166, 200, 0, 16);
        sel16 = 1'b0;

        // Key held for 20 cycles in IDLE advances exactly one state
        @(negedge clock);
        dv8 = 1'b1;
        #1 check("nxStateLed on rise", nx8, 1);
        check("still IDLE before edge", pr8, 0);
        repeat (20) @(negedge clock);
        check("held key: LOAD_A only", pr8, 1);
        dv8 = 1'b0;
        do_reset();

        // Press that begins during CALC is lost
        press(16'd0);
        press(16'd100);
        press(16'd7);
        check("in CALC", pr8, 3);
        @(negedge clock);
        dv8 = 1'b1;
        repeat (12) @(negedge clock);
        check("CALC press ignored", pr8, 4);
        check("quotient after CALC press", dout8, 14);
        dv8 = 1'b0;
        @(negedge clock);
        check("stays SHOW_Q", pr8, 4);
        press(16'd0);
        check("fresh press to SHOW_R", pr8, 5);
        check("remainder after CALC press", dout8, 2);
        do_reset();

        // Reset in cycle 4 of CALC with the key held high
        press(16'd0);
        press(16'd100);
        press(16'd7);
        repeat (3) @(negedge clock);
        check("busy before mid-CALC reset", busy8, 1);
        dv8   = 1'b1;
        reset = 1'b1;
        #1;
        check("mid reset dout", dout8, 0);
        check("mid reset busy", busy8, 0);
        check("mid reset prStateLed", pr8, 0);
        check("mid reset nxStateLed", nx8, 0);
        check("mid reset divZero", dz8, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("held key after reset stays IDLE", pr8, 0);
        dv8 = 1'b0;
        @(negedge clock);
        press(16'd0);
        check("real press after reset", pr8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/divisor_sequencial.md
# divisor_sequencial

Parametrised, key-stepped sequential divider: controller and datapath in one block. The operator enters dividend and divisor on the switches (`din`) and confirms each with the `dv` key. The block computes an unsigned restoring division one bit per clock, then steps the display through quotient and remainder. It replaces the fixed 2-bit-opcode divider controller, adding:
- generic operand width;
- rising-edge key detection;
- an internal iteration counter;
- divide-by-zero handling.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width (≥2).
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `dv` in 1: debounced confirm key, level; only its rising edge acts.
- `din` in WIDTH: operand from switches.
- `dout` out WIDTH: value to display.
- `busy` out 1: high while dividing.
- `divZero` out 1: divisor was zero in the current operation.
- `prStateLed` out 3: present state encoding.
- `nxStateLed` out 3: combinational next-state encoding.

## Operation
- Edge detect: register `dvQ` samples `dv` every clock. `dvRise = dv & ~dvQ`. `dvQ` resets to 1, so a key held through reset is not a press.
- States and encodings: IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, SHOW_Q=4, SHOW_R=5. Codes 6–7 go to IDLE on the next clock with all outputs at IDLE values.
- IDLE:
  - `dout`=0.
  - `dvRise` → LOAD_A.
- LOAD_A:
  - `dout`=`din` (live).
  - `dvRise`: A←`din`, → LOAD_B.
- LOAD_B:
  - `dout`=`din` (live).
  - `dvRise` with `din`≠0: B←`din`, rem←0, quo←A, cnt←0, → CALC.
  - `dvRise` with `din`=0: B←0, quo←all ones, rem←A, `divZero`←1, → SHOW_Q. CALC is skipped.
- CALC:
  - `busy`=1, `dout`=0. `dv` is ignored.
  - Per clock: form t = {rem, quo[WIDTH-1]} (WIDTH+1 bits); quo←quo<<1.
  - If t ≥ B: rem←t−B and quo[0]←1; else rem←t[WIDTH-1:0].
  - cnt increments; cnt is ⌈log2(WIDTH+1)⌉ bits.
  - After the iteration with cnt=WIDTH−1 → SHOW_Q.
- SHOW_Q:
  - `dout`=quo.
  - `dvRise` → SHOW_R.
- SHOW_R:
  - `dout`=rem.
  - `dvRise` → IDLE and `divZero`←0.
- All arithmetic is unsigned. No overflow is possible, since quo<2^WIDTH and rem<B.
- A, B, quo, rem and cnt hold their value in every state that does not write them.
- A press that begins during CALC is lost. Its rising edge is consumed while `dv` is ignored, so the operator must release and press again.

## Timing
- Reset (asynchronous, any state including mid-CALC):
  - state=IDLE; A, B, quo, rem, cnt = 0; `dvQ`=1.
  - `dout`=0, `busy`=0, `divZero`=0, `prStateLed`=0.
  - `nxStateLed`=0 while `reset` is asserted.
- State, A, B, quo, rem, cnt and `divZero` change only on the rising edge of `clock`.
- `dvRise` seen in cycle N: the transition occurs at the edge ending cycle N, and the new `prStateLed` is visible in cycle N+1.
- Holding `dv` for any number of cycles advances exactly one state.
- Latency, LOAD_B press edge → SHOW_Q entered:
  - WIDTH+1 edges for B≠0;
  - 1 edge for B=0.
- `busy` is high for exactly WIDTH cycles per division.
- Output timing:
  - `dout` and `busy` are combinational from state and registers; `dout` in LOAD states follows `din` with zero latency.
  - `nxStateLed` is combinational from state, `dvRise`, `din` and cnt.

## Test plan
- WIDTH=8, key in A=100, B=7:
  - `busy` high for 8 cycles;
  - SHOW_Q `dout`=14, SHOW_R `dout`=2, `divZero`=0.
- WIDTH=8, A=37, B=0:
  - no CALC, `busy` never high;
  - SHOW_Q `dout`=255, SHOW_R `dout`=37, `divZero`=1;
  - after the next press: IDLE, `divZero`=0.
- WIDTH=8, A=5, B=9 → Q=0, R=5. A=255, B=1 → Q=255, R=0. A=0, B=3 → Q=0, R=0.
- WIDTH=16, A=50000, B=300:
  - `busy` high for 16 cycles;
  - Q=166, R=200.
- `dv` held high for 20 cycles in IDLE → only LOAD_A is reached. `dv` pressed during CALC → ignored, and the state stays SHOW_Q until a fresh press.
- Reset asserted mid-CALC (cycle 4 of 8) with `dv` high:
  - all outputs 0 immediately;
  - after release with `dv` still high: stays in IDLE;
  - the next real press → LOAD_A.
